denormalizer: RTL and testbench

Inverse of the glove normalizer. It converts eight signed Q8.8 normalized values (classifier or reconstruction domain) back to raw signed-integer sensor units using `data = round(norm * std / 256) + mean`, with saturation to 16 bits. All eight channels share one multiplier and are processed serially, one channel per cycle. Outputs update atomically together with a one-cycle `o_finished` pulse. It sits downstream of the model/replay path, wherever raw-scale sensor values are needed again (debug display, UART dump, loopback checks against the normalizer).

---
 rtl/glove_norm_pkg.sv | 24 ++
 rtl/denorm_lane.sv | 37 +++
 rtl/denormalizer.sv | 104 ++++++++++
 tb/tb_denormalizer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/glove_norm_pkg.sv
// Shared calibration tables and fixed-point format for the glove normalizer/denormalizer pair.
// Both blocks import these tables so the forward and inverse transforms stay consistent.
package glove_norm_pkg;

  localparam int N_CH = 8;
  localparam int FRAC = 8;

  localparam logic signed [15:0] MEAN [0:N_CH-1] = '{
    16'sh0305, -16'sh0058, 16'sh0101, 16'sh013e,
    16'sh0144, 16'sh014e, 16'sh0154, 16'sh0133
  };

  localparam logic signed [15:0] STD [0:N_CH-1] = '{
    16'sh01f1, 16'sh00fd, 16'sh0110, 16'sh0013,
    16'sh002d, 16'sh002b, 16'sh0024, 16'sh0029
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/denorm_lane.sv
// Combinational single-channel inverse transform: round(norm * std / 2^FRAC) + mean,
// with rounding half toward +inf and saturation to the signed 16-bit range.
module denorm_lane #(
  parameter int FRAC = glove_norm_pkg::FRAC
) (
  input  logic signed [15:0] norm,
  input  logic signed [15:0] std,
  input  logic signed [15:0] mean,
  output logic signed [15:0] result
);

  localparam logic signed [32:0] RND_HALF = 33'sd1 <<< (FRAC - 1);

  logic signed [31:0]       prod_s;
  logic signed [32:0]       rnd_s;
  logic signed [32-FRAC:0]  shf_s;
  logic signed [25:0]       sum_s;

  assign prod_s = 32'(norm) * 32'(std);
  assign rnd_s  = 33'(prod_s) + RND_HALF;
  // Dropping the low FRAC bits of a signed value is an arithmetic shift (floor).
  assign shf_s  = rnd_s[32:FRAC];
  assign sum_s  = 26'(shf_s) + 26'(mean);

  // Saturate the widened sum back into 16 bits.
  always_comb begin
    result = sum_s[15:0];
    if (sum_s > 26'sd32767) begin
      result = 16'sh7fff;
    end else if (sum_s < -26'sd32768) begin
      result = 16'sh8000;
    end else begin
      result = sum_s[15:0];
    end
  end

endmodule

// File: rtl/denormalizer.sv
// Serial denormalizer: one shared lane walks the eight channels, results are staged in a
// shadow buffer and published to o_data all at once with a one-cycle o_finished pulse.
module denormalizer #(
  parameter int N_CH = 8,
  parameter int FRAC = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic signed [15:0] i_norm [0:N_CH-1],
  output logic signed [15:0] o_data [0:N_CH-1],
  output logic               o_busy,
  output logic               o_finished
);

  localparam int               IDX_W    = $clog2(N_CH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

  glove_norm_pkg::state_e state_r;
  glove_norm_pkg::state_e state_nx_s;

  logic [IDX_W-1:0]   idx_r;
  logic signed [15:0] norm_buf_r [0:N_CH-1];
  logic signed [15:0] shadow_r   [0:N_CH-1];
  logic signed [15:0] lane_res_s;
  logic               start_s;
  logic               last_s;

  denorm_lane #(
    .FRAC (FRAC)
  ) u_lane (
    .norm   (norm_buf_r[idx_r]),
    .std    (glove_norm_pkg::STD[idx_r]),
    .mean   (glove_norm_pkg::MEAN[idx_r]),
    .result (lane_res_s)
  );

  // Next-state logic; start_s/last_s mark the latch and publish edges.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      glove_norm_pkg::S_IDLE: begin
        if (i_start) begin
          state_nx_s = glove_norm_pkg::S_CALC;
          start_s    = 1'b1;
        end else begin
          state_nx_s = glove_norm_pkg::S_IDLE;
        end
      end
      glove_norm_pkg::S_CALC: begin
        if (idx_r == IDX_LAST) begin
          state_nx_s = glove_norm_pkg::S_DONE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = glove_norm_pkg::S_CALC;
        end
      end
      glove_norm_pkg::S_DONE: state_nx_s = glove_norm_pkg::S_IDLE;
      default:                state_nx_s = glove_norm_pkg::S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_r <= glove_norm_pkg::S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Input latch, channel walk, shadow staging and atomic output publish.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      idx_r      <= '0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        norm_buf_r[i] <= 16'sd0;
        shadow_r[i]   <= 16'sd0;
        o_data[i]     <= 16'sd0;
      end
    end else begin
      o_busy     <= (state_nx_s != glove_norm_pkg::S_IDLE);
      o_finished <= last_s;
      if (start_s) begin
        norm_buf_r <= i_norm;
        idx_r      <= '0;
      end else if (last_s) begin
        idx_r <= '0;
        for (int i = 0; i < N_CH - 1; i++) begin
          o_data[i] <= shadow_r[i];
        end
        o_data[N_CH-1] <= lane_res_s;
      end else if (state_r == glove_norm_pkg::S_CALC) begin
        shadow_r[idx_r] <= lane_res_s;
        idx_r           <= idx_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_denormalizer.sv
// Randomized self-checking bench for denormalizer against a floor-division reference model.
module tb_denormalizer;
  import glove_norm_pkg::*;

  typedef logic signed [15:0] vec_t [0:7];

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  vec_t        i_norm;
  vec_t        o_data;
  logic        o_busy;
  logic        o_finished;

  int n_checks = 0;
  int n_errors = 0;

  denormalizer #(.N_CH(8), .FRAC(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_norm     (i_norm),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_finished (o_finished)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // data = floor((norm*std + 128) / 256) + mean, clamped to 16 bits
  function automatic logic signed [15:0] ref_denorm(input int norm, input int ch);
    longint num;
    longint q;
    num = longint'(norm) * longint'(STD[ch]) + 64'sd128;
    q = num / 256;
    if ((num % 256) != 0 && num < 0) q = q - 1;
    q = q + longint'(MEAN[ch]);
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  // forward normalizer: round((raw - mean) * 256 / std)
  function automatic int ref_norm(input int raw, input int ch);
    real r;
    r = real'(raw - int'(MEAN[ch])) * 256.0 / real'(STD[ch]);
    return int'($floor(r + 0.5));
  endfunction

  // o_data may only move in the o_finished cycle (outside reset)
  vec_t prev_data;
  always @(negedge i_clk) begin
    bit changed;
    changed = 1'b0;
    for (int c = 0; c < 8; c++) if (o_data[c] !== prev_data[c]) changed = 1'b1;
    if (!i_rst_n && changed) check("data_only_on_finish", o_finished, 1);
    prev_data = o_data;
  end

  task automatic do_run(input vec_t nv, input bit poke);
    int lat;
    int extra;
    @(negedge i_clk);
    i_norm  = nv;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int c = 0; c < 8; c++) i_norm[c] = 16'($urandom);
    check("busy_after_start", o_busy, 1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge i_clk);
      #1;
      if (poke) i_start = (k == 2);
      if (o_finished) lat = k;
      else if (k < 8) check("busy_during_run", o_busy, 1);
    end
    i_start = 1'b0;
    check("latency", lat, 8);
    check("busy_in_finish", o_busy, 1);
    for (int c = 0; c < 8; c++)
      check($sformatf("data_ch%0d", c), o_data[c], ref_denorm(int'(nv[c]), c));
    @(posedge i_clk);
    #1;
    check("finished_one_cycle", o_finished, 0);
    check("busy_after_finish", o_busy, 0);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(posedge i_clk);
        #1;
        if (o_finished || o_busy) extra++;
      end
      check("ignored_start", extra, 0);
    end
  endtask

  initial begin
    vec_t v;
    int   pulses;
    int   prev_k;
    int   fin_cnt;
    int   raw [0:7];
    int   tol;
    int   diff;

    i_rst_n = 1'b1;
    i_start = 1'b0;
    for (int c = 0; c < 8; c++) i_norm[c] = 16'sd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check("reset_finished", o_finished, 0);
    check("reset_busy", o_busy, 0);
    for (int c = 0; c < 8; c++) check($sformatf("reset_data_ch%0d", c), o_data[c], 0);

    for (int c = 0; c < 8; c++) v[c] = 16'sh0100;
    do_run(v, 1'b0);
    check("one_ch0", o_data[0], 32'(16'sh04f6));
    check("one_ch3", o_data[3], 32'(16'sh0151));

    for (int c = 0; c < 8; c++) v[c] = 16'sh0000;
    do_run(v, 1'b0);
    check("zero_ch1", o_data[1], 32'(-16'sh0058));

    v[3] = 16'sh0080;
    do_run(v, 1'b0);
    check("round_ch3", o_data[3], 32'(16'sh0148));

    v[0] = 16'sh7fff;
    do_run(v, 1'b0);
    check("sat_hi_ch0", o_data[0], 32'(16'sh7fff));
    v[0] = 16'sh8000;
    do_run(v, 1'b0);
    check("sat_lo_ch0", o_data[0], 32'(16'sh8000));

    for (int c = 0; c < 8; c++) v[c] = 16'($urandom);
    do_run(v, 1'b1);

    // start held high: back-to-back runs every 10 cycles
    for (int c = 0; c < 8; c++) v[c] = 16'($urandom);
    @(negedge i_clk);
    i_norm  = v;
    i_start = 1'b1;
    pulses  = 0;
    prev_k  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_finished) begin
        if (pulses == 0) check("stream_first", k, 8);
        else check("stream_spacing", k - prev_k, 10);
        check("stream_ch5", o_data[5], ref_denorm(int'(v[5]), 5));
        prev_k = k;
        pulses++;
      end
    end
    i_start = 1'b0;
    check("stream_pulses", pulses, 4);
    repeat (3) @(posedge i_clk);

    // reset asserted mid-run just after E4
    for (int c = 0; c < 8; c++) v[c] = 16'sh0100;
    @(negedge i_clk);
    i_norm  = v;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    check("midrst_busy", o_busy, 0);
    for (int c = 0; c < 8; c++) check($sformatf("midrst_data_ch%0d", c), o_data[c], 0);
    fin_cnt = 0;
    repeat (15) begin
      @(posedge i_clk);
      #1;
      if (o_finished) fin_cnt++;
    end
    check("midrst_no_finish", fin_cnt, 0);
    for (int c = 0; c < 8; c++) check($sformatf("midrst_hold_ch%0d", c), o_data[c], 0);

    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 8; c++) v[c] = 16'($urandom);
      do_run(v, 1'b0);
    end

    // loopback through the forward normalizer
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 8; c++) begin
        tol = 100 * int'(STD[c]);
        if (tol > 20000) tol = 20000;
        raw[c] = int'(MEAN[c]) + int'($urandom_range(0, 2 * tol)) - tol;
        v[c] = 16'(ref_norm(raw[c], c));
      end
      do_run(v, 1'b0);
      for (int c = 0; c < 8; c++) begin
        tol  = (int'(STD[c]) + 255) / 256;
        diff = int'(o_data[c]) - raw[c];
        if (diff < 0) diff = -diff;
        check($sformatf("loopback_ch%0d_within_tol", c), (diff <= tol), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
